instr_encode_loader: RTL and testbench
======================================

# instr_encode_loader

Packs field-level instruction descriptions (opcode, Rs, Rt, Rd, shamt, funct, imm) into 32-bit KGP-RISC instruction words and writes them sequentially into instruction memory. It is the write-side counterpart of the instruction decoder: every word it emits decodes back to the same fields. It sits between the testbench or boot source and the instruction memory write port. It streams one instruction per cycle until HALT, memory full, or reset.

## Interface
Parameters:
- ADDR_W, 10: instruction-memory word-address width.
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load session from IDLE or DONE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block accepts fields this cycle.
- opcode  in  6  instruction opcode.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- funct  in  6  R-type function code.
- imm  in  32  signed immediate.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction word.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  state is RUN.
- done  out  1  session finished (sticky until start).
- err_imm  out  1  sticky: an instruction was rejected for immediate range.
- err_full  out  1  sticky: memory filled before HALT.

## Operation
- Encoding rules:
  - R-type (000000): {op, rs, rt, rd, shamt, funct}.
  - PUSH (010011) and POP (010100): {op, rs, 21'b0}.
  - CALL (010101): {op, 10'b0, imm[15:0]}.
  - RET (011000), HALT (010110) and NOP (010111): {op, 26'b0}.
  - MOVE (010010): {op, rs, rt, 16'b0}.
  - Every other opcode: {op, rs, rt, imm[15:0]}.
- Unused input fields are ignored.
- Immediate range check:
  - Applies to CALL and to the default I-type opcodes only.
  - imm[31:15] must be all-equal.
  - On violation: the word is not written, addr and count are unchanged, err_imm is set, and the FSM stays in RUN.
- FSM states:
  - IDLE: in_ready=0. start -> RUN; load addr=BASE_ADDR, count=0, clear done, err_imm and err_full.
  - RUN: in_ready=1.
    - Accepted HALT -> DONE.
    - Accepted write at addr 2^ADDR_W-1 that is not HALT -> DONE, and err_full is set.
    - start is ignored in RUN.
  - DONE: done=1, in_ready=0. start -> RUN with the same initialisation as from IDLE.
- If start and in_valid arrive together in IDLE or DONE, the fields are not accepted.
- The address counter never wraps; the full check ends the session first.

## Timing
- Transfer occurs on a rising edge when in_valid && in_ready.
- in_ready is a Moore output: high exactly when state is RUN.
- Write latency is 1 cycle. A transfer at edge k gives mem_we=1 for one cycle after edge k, with registered mem_addr and mem_wdata.
- addr and count advance at that same edge k.
- Throughput: one instruction per cycle, with no bubbles between back-to-back writes.
- After an accepted HALT, done and the HALT write are visible in the same cycle. in_ready is low from that cycle onward.
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, in_ready=0, busy=0, done=0, err_imm=0, err_full=0, state=IDLE.
- Reset applies immediately (asynchronous). A pending mem_we is dropped.

## Structure
- Shared package isa_pkg holds:
  - the opcode localparams OP_RTYPE, OP_MOVE, OP_PUSH, OP_POP, OP_CALL, OP_HALT, OP_NOP, OP_RET;
  - SP_REG=16;
  - the field bit positions.
- The decoder uses the same package.
- One combinational sub-module, instr_packer, takes the fields and produces word[31:0] and imm_ok.
- The top level holds the FSM, the address and count registers, and the output registers.

## Test plan
- R-type: op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> mem_wdata=0x00221820 at addr 0, mem_we one cycle after accept, count=1.
- PUSH with rs=5 and rt=rd=7 -> 0x4CA00000. MOVE with rs=1, rt=2, imm=0x1234 -> 0x48220000.
- CALL with imm=0xFFFFFFFC -> 0x5400FFFC. Next, op=000001 with rs=1, rt=2, imm=0x00010000 -> no mem_we, err_imm=1, count unchanged, next instruction written at the next address.
- Three back-to-back NOPs then HALT -> 0x5C000000 at addrs 0..2, 0x58000000 at addr 3 with mem_we high on four consecutive cycles. done=1 in the HALT-write cycle, count=4, in_ready=0. A new start -> addr restarts at 0 and flags clear.
- ADDR_W=2, five NOPs held valid -> exactly four writes (addrs 0..3), err_full=1, done=1, fifth not accepted.
- rst_n low in RUN, in the cycle after an accept -> all outputs reset immediately, no write occurs. After release plus start, writing resumes at BASE_ADDR.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared KGP-RISC instruction-set definitions.
// Holds the opcode values, the stack-pointer register index, the bit
// positions of each instruction field, the loader FSM state type and a
// helper that checks whether a 32-bit immediate fits the 16-bit field.
// The instruction decoder imports this same package, so an encoder/decoder
// pair can never disagree on field placement.
package isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MOVE  = 6'b010010;
  localparam logic [5:0] OP_PUSH  = 6'b010011;
  localparam logic [5:0] OP_POP   = 6'b010100;
  localparam logic [5:0] OP_CALL  = 6'b010101;
  localparam logic [5:0] OP_HALT  = 6'b010110;
  localparam logic [5:0] OP_NOP   = 6'b010111;
  localparam logic [5:0] OP_RET   = 6'b011000;

  localparam logic [4:0] SP_REG = 5'd16;

  // Least-significant bit of each field within the 32-bit word.
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  // A value fits in a signed 16-bit field when bits 31..15 are all copies
  // of the sign bit.
  function automatic logic imm_fits16(input logic signed [31:0] imm);
    return (imm[31:15] == '0) || (imm[31:15] == '1);
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational instruction packer.
// Ports:
//   opcode, rs, rt, rd, shamt, funct, imm : instruction fields
//   word   : encoded 32-bit instruction word
//   imm_ok : low when an immediate-carrying opcode has an immediate that
//            does not fit the signed 16-bit field
module instr_packer
  import isa_pkg::*;
(
  input  logic        [5:0]  opcode,
  input  logic        [4:0]  rs,
  input  logic        [4:0]  rt,
  input  logic        [4:0]  rd,
  input  logic        [4:0]  shamt,
  input  logic        [5:0]  funct,
  input  logic signed [31:0] imm,
  output logic        [31:0] word,
  output logic               imm_ok
);

  logic [31:0] op_f, rs_f, rt_f, rd_f, sh_f, fn_f, imm_f;

  assign op_f  = 32'(opcode) << OP_LSB;
  assign rs_f  = 32'(rs)     << RS_LSB;
  assign rt_f  = 32'(rt)     << RT_LSB;
  assign rd_f  = 32'(rd)     << RD_LSB;
  assign sh_f  = 32'(shamt)  << SHAMT_LSB;
  assign fn_f  = 32'(funct)  << FUNCT_LSB;
  assign imm_f = 32'(imm[15:0]) << IMM_LSB;

  always_comb begin
    word   = op_f;
    imm_ok = 1'b1;
    case (opcode)
      OP_RTYPE:                word = op_f | rs_f | rt_f | rd_f | sh_f | fn_f;
      OP_PUSH, OP_POP:         word = op_f | rs_f;
      OP_MOVE:                 word = op_f | rs_f | rt_f;
      OP_RET, OP_HALT, OP_NOP: word = op_f;
      OP_CALL: begin
        word   = op_f | imm_f;
        imm_ok = imm_fits16(imm);
      end
      default: begin
        word   = op_f | rs_f | rt_f | imm_f;
        imm_ok = imm_fits16(imm);
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encoder / loader.
// Streams field-level instruction descriptions into instruction memory, one
// encoded word per cycle, starting at BASE_ADDR after a start pulse and
// ending on HALT or when the last memory word is written.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begins a session from IDLE or DONE
//   in_valid / in_ready   : field handshake (in_ready high exactly in RUN)
//   opcode..imm           : instruction fields
//   mem_we/addr/wdata     : registered instruction-memory write port
//   count                 : words written this session
//   busy, done            : RUN / DONE state flags
//   err_imm, err_full     : sticky session error flags
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic        [5:0]   opcode,
  input  logic        [4:0]   rs,
  input  logic        [4:0]   rt,
  input  logic        [4:0]   rd,
  input  logic        [4:0]   shamt,
  input  logic        [5:0]   funct,
  input  logic signed [31:0]  imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic                err_imm,
  output logic                err_full
);

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word_p0;
  logic              imm_ok_p0;
  logic              accept_p0, wr_p0, halt_p0, last_p0, begin_p0;

  instr_packer u_packer (
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm    (imm),
    .word   (word_p0),
    .imm_ok (imm_ok_p0)
  );

  // Stage 0: handshake and write decision on the incoming fields
  assign accept_p0 = in_valid && (state == ST_RUN);
  assign wr_p0     = accept_p0 && imm_ok_p0;
  assign halt_p0   = (opcode == OP_HALT);
  assign last_p0   = &addr;
  assign begin_p0  = start && (state != ST_RUN);

  assign in_ready = (state == ST_RUN);
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
      ST_RUN:           if (wr_p0 && (halt_p0 || last_p0)) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Stage 1: registered memory write port, address/count and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      addr      <= BASE_ADDR;
      count     <= '0;
      err_imm   <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      mem_we <= wr_p0;
      if (wr_p0) begin
        mem_addr  <= addr;
        mem_wdata <= word_p0;
        count     <= count + 1'b1;
        // Hold at the top address: the session ends there, so no wrap.
        if (!last_p0) addr <= addr + 1'b1;
        if (last_p0 && !halt_p0) err_full <= 1'b1;
      end
      if (accept_p0 && !imm_ok_p0) err_imm <= 1'b1;
      if (begin_p0) begin
        addr     <= BASE_ADDR;
        count    <= '0;
        err_imm  <= 1'b0;
        err_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader (ADDR_W=2, BASE_ADDR=0).
module tb_instr_encode_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    opcode = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]    funct = '0;
  logic [31:0]   imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          busy, done, err_imm, err_full;

  instr_encode_loader #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .busy(busy), .done(done), .err_imm(err_imm), .err_full(err_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  // Reference model state.
  bit m_run, m_done, m_eimm, m_efull;
  int m_addr, m_count;

  function automatic logic [31:0] ref_word(input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [31:0] im);
    logic [31:0] base;
    base = {op, 26'd0};
    case (op)
      6'h00:               return base | (s << 21) | (t << 16) | (d << 11) | (sh << 6) | fn;
      6'h13, 6'h14:        return base | (s << 21);
      6'h15:               return base | (im & 32'hFFFF);
      6'h18, 6'h16, 6'h17: return base;
      6'h12:               return base | (s << 21) | (t << 16);
      default:             return base | (s << 21) | (t << 16) | (im & 32'hFFFF);
    endcase
  endfunction

  function automatic bit ref_imm_bad(input logic [5:0] op, input logic [31:0] im);
    int v;
    bit uses_imm;
    v = $signed(im);
    uses_imm = !(op inside {6'h00, 6'h12, 6'h13, 6'h14, 6'h16, 6'h17, 6'h18});
    return uses_imm && (v > 32767 || v < -32768);
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_eimm = 0; m_efull = 0; m_addr = 0; m_count = 0;
  endtask

  // Applies the inputs that were present at the last rising edge.
  task automatic model_update();
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_eimm = 0; m_efull = 0; m_addr = 0; m_count = 0;
      end
    end else if (in_valid) begin
      if (ref_imm_bad(opcode, imm)) begin
        m_eimm = 1;
      end else begin
        e.addr = m_addr;
        e.data = ref_word(opcode, rs, rt, rd, shamt, funct, imm);
        e.cyc  = cyc;
        q.push_back(e);
        m_count++;
        if (opcode == 6'h16) begin
          m_run = 0; m_done = 1;
        end else if (m_addr == DEPTH - 1) begin
          m_run = 0; m_done = 1; m_efull = 1;
        end
        m_addr++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    chk("in_ready", in_ready, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("count", count, m_count);
    chk("err_imm", err_imm, m_eimm);
    chk("err_full", err_full, m_efull);
  endtask

  task automatic set_ins(input logic v, input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [31:0] im);
    in_valid = v; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im;
  endtask

  task automatic begin_session();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    start = 1;
    tick();
    start = 0;
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {31'd0, mem_we}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [5:0] optab [12];

  initial begin
    model_reset();
    optab = '{6'h00, 6'h12, 6'h13, 6'h14, 6'h15, 6'h18, 6'h16, 6'h17,
              6'h01, 6'h08, 6'h23, 6'h00};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_imm", err_imm, 0);
    chk("rst_err_full", err_full, 0);
    rst_n = 1;
    tick();

    // Session A: R-type, PUSH, MOVE, HALT at the last address.
    begin_session();
    set_ins(1, 6'h00, 1, 2, 3, 0, 6'h20, 0);        tick();
    chk("rtype_we", mem_we, 1);
    chk("rtype_word", mem_wdata, 32'h00221820);
    set_ins(1, 6'h13, 5, 7, 7, 0, 0, 0);            tick();
    chk("push_word", mem_wdata, 32'h4CA00000);
    set_ins(1, 6'h12, 1, 2, 0, 0, 0, 32'h1234);     tick();
    chk("move_word", mem_wdata, 32'h48220000);
    set_ins(1, 6'h16, 0, 0, 0, 0, 0, 0);            tick();
    chk("halt_last_word", mem_wdata, 32'h58000000);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);                tick();

    // Session B: CALL, rejected immediate, then next address used.
    begin_session();
    set_ins(1, 6'h15, 0, 0, 0, 0, 0, 32'hFFFFFFFC); tick();
    chk("call_word", mem_wdata, 32'h5400FFFC);
    set_ins(1, 6'h01, 1, 2, 0, 0, 0, 32'h00010000); tick();
    chk("bad_imm_no_we", mem_we, 0);
    set_ins(1, 6'h17, 0, 0, 0, 0, 0, 0);            tick();
    chk("after_bad_addr", 32'(mem_addr), 1);
    set_ins(1, 6'h16, 0, 0, 0, 0, 0, 0);            tick();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);                tick();

    // Session C: three NOPs then HALT, back to back.
    begin_session();
    repeat (3) begin
      set_ins(1, 6'h17, 0, 0, 0, 0, 0, 0); tick();
      chk("nop_we", mem_we, 1);
    end
    set_ins(1, 6'h16, 0, 0, 0, 0, 0, 0); tick();
    chk("halt_we", mem_we, 1);
    chk("halt_addr", 32'(mem_addr), 3);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Session D: NOPs held valid overflow the memory; start+valid in DONE.
    begin_session();
    set_ins(1, 6'h17, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    start = 1; tick(); start = 0;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Session E: reset in the cycle after an accept drops the write.
    begin_session();
    set_ins(1, 6'h17, 0, 0, 0, 0, 0, 0); tick();
    rst_n = 0;
    #1;
    q.delete();
    model_reset();
    chk("async_rst_we", mem_we, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_addr", 32'(mem_addr), 0);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
    begin_session();
    set_ins(1, 6'h13, 9, 0, 0, 0, 0, 0); tick();
    chk("resume_addr", 32'(mem_addr), 0);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      logic [31:0] im;
      op = optab[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if ($urandom_range(0, 1) == 0) im = 32'($signed($urandom_range(0, 65535)) - 32768);
      else                          im = $urandom;
      start = m_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      set_ins($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 6'($urandom), im);
      tick();
    end
    start = 0;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
